// File: rtl/uart_serial_path.sv
// One-bit-per-clock UART transmit and receive paths sharing a parity select.
// Define UART_STOP_CHECK_EN to flag a stop bit sampled as 0 as a framing error.
module uart_serial_path #(
    parameter int WIDTH_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic                  err,
    input  logic [WIDTH_SIZE-1:0] input_tx,
    input  logic                  PF,
    output logic                  Tx,
    output logic                  ready,
    input  logic                  Rx,
    output logic                  rx_valid,
    output logic                  rx_err,
    output logic [WIDTH_SIZE-1:0] rx_data
);

    localparam int CNT_W = $clog2(WIDTH_SIZE + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH_SIZE - 1);

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [1:0] RX_IDLE   = 2'd0;
    localparam logic [1:0] RX_DATA   = 2'd1;
    localparam logic [1:0] RX_PARITY = 2'd2;
    localparam logic [1:0] RX_STOP   = 2'd3;

    function automatic logic parity_bit(input logic [WIDTH_SIZE-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    logic [2:0]            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic [WIDTH_SIZE-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d;

    // Parity (with optional inversion) is resolved at acceptance so later input changes cannot leak in.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (valid) begin
                    tx_state_d = TX_START;
                    tx_shift_d = input_tx;
                    tx_par_d   = parity_bit(input_tx, PF) ^ err;
                end
            end
            TX_START: begin
                tx_state_d = TX_DATA;
                tx_cnt_d   = '0;
            end
            TX_DATA: begin
                tx_shift_d = tx_shift_q >> 1;
                tx_cnt_d   = tx_cnt_q + CNT_W'(1);
                if (tx_cnt_q == LAST_BIT) tx_state_d = TX_PARITY;
            end
            TX_PARITY: tx_state_d = TX_STOP;
            default:   tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        case (tx_state_q)
            TX_START:  Tx = 1'b0;
            TX_DATA:   Tx = tx_shift_q[0];
            TX_PARITY: Tx = tx_par_q;
            default:   Tx = 1'b1;
        endcase
    end

    assign ready = (tx_state_q == TX_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        tx_shift_q <= tx_shift_d;
        tx_par_q   <= tx_par_d;
    end

    logic [1:0]            rx_state_q, rx_state_d;
    logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [WIDTH_SIZE-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH_SIZE:0]   rx_shift_in;
    logic                  rx_pf_q, rx_pf_d;
    logic                  rx_parbit_q, rx_parbit_d;
    logic                  rx_valid_q, rx_err_q;
    logic [WIDTH_SIZE-1:0] rx_data_q;
    logic                  stop_bad;

`ifdef UART_STOP_CHECK_EN
    assign stop_bad = ~Rx;
`else
    assign stop_bad = 1'b0;
`endif

    // New bits enter at the MSB so the first (LSB) bit ends up in bit 0.
    assign rx_shift_in = {Rx, rx_shift_q};

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_pf_d     = rx_pf_q;
        rx_parbit_d = rx_parbit_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (!Rx) begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = '0;
                    rx_pf_d    = PF;
                end
            end
            RX_DATA: begin
                rx_shift_d = rx_shift_in[WIDTH_SIZE:1];
                rx_cnt_d   = rx_cnt_q + CNT_W'(1);
                if (rx_cnt_q == LAST_BIT) rx_state_d = RX_PARITY;
            end
            RX_PARITY: begin
                rx_parbit_d = Rx;
                rx_state_d  = RX_STOP;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_valid_q <= (rx_state_q == RX_STOP);
            if (rx_state_q == RX_STOP) begin
                rx_data_q <= rx_shift_q;
                rx_err_q  <= (parity_bit(rx_shift_q, rx_pf_q) ^ rx_parbit_q) | stop_bad;
            end
        end
    end

    always_ff @(posedge clk) begin
        rx_shift_q  <= rx_shift_d;
        rx_pf_q     <= rx_pf_d;
        rx_parbit_q <= rx_parbit_d;
    end

    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_uart_serial_path.sv
// Bench for uart_serial_path: loopback frames, back-to-back, mid-frame reset, directly driven Rx frames.
module tb_uart_serial_path;

    localparam int W  = 16;
    localparam int FL = W + 3;
`ifdef UART_STOP_CHECK_EN
    localparam bit STOP_CHK = 1'b1;
`else
    localparam bit STOP_CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         valid = 1'b0;
    logic         err = 1'b0;
    logic         PF = 1'b0;
    logic [W-1:0] input_tx = '0;
    logic         Tx, ready, rx_valid, rx_err;
    logic [W-1:0] rx_data;
    logic         loop_en = 1'b1;
    logic         rx_drv = 1'b1;
    logic         rx_line;

    int checks = 0;
    int failures = 0;

    assign rx_line = loop_en ? Tx : rx_drv;

    always #5 clk = ~clk;

    uart_serial_path #(.WIDTH_SIZE(W)) dut (
        .clk(clk), .reset(reset), .valid(valid), .err(err),
        .input_tx(input_tx), .PF(PF), .Tx(Tx), .ready(ready),
        .Rx(rx_line), .rx_valid(rx_valid), .rx_err(rx_err), .rx_data(rx_data)
    );

    // Frame as sent on the line, index 0 first: start, data LSB first, parity, stop.
    function automatic logic [FL-1:0] frame_bits(input logic [W-1:0] word, input logic pf, input logic inv);
        logic [FL-1:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < W; i++) f[i+1] = word[i];
        f[W+1] = (^word) ^ pf ^ inv;
        f[W+2] = 1'b1;
        return f;
    endfunction

    task automatic test_reset;
        reset = 1'b0; valid = 1'b1; input_tx = W'($urandom); loop_en = 1'b0; rx_drv = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++; if (Tx !== 1'b1) begin failures++; $display("FAIL rst_tx c=%0d got %b want 1", c, Tx); end
            checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready c=%0d got %b want 1", c, ready); end
            checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rst_rx_valid c=%0d got %b want 0", c, rx_valid); end
            checks++; if (rx_err !== 1'b0) begin failures++; $display("FAIL rst_rx_err c=%0d got %b want 0", c, rx_err); end
            checks++; if (rx_data !== '0) begin failures++; $display("FAIL rst_rx_data c=%0d got %h want 0", c, rx_data); end
        end
        valid = 1'b0; rx_drv = 1'b1; loop_en = 1'b1; reset = 1'b1;
    endtask

    task automatic test_loopback(input logic [W-1:0] word, input logic pf, input logic inv);
        logic [FL-1:0] fb;
        fb = frame_bits(word, pf, inv);
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL lb_ready_idle got %b want 1", ready); end
        valid = 1'b1; input_tx = word; PF = pf; err = inv;
        for (int k = 0; k < FL; k++) begin
            @(negedge clk);
            checks++; if (Tx !== fb[k]) begin failures++; $display("FAIL lb_tx word=%h bit=%0d got %b want %b", word, k, Tx, fb[k]); end
            checks++; if (ready !== 1'b0) begin failures++; $display("FAIL lb_ready_busy bit=%0d got %b want 0", k, ready); end
            checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL lb_rx_valid_early bit=%0d got %b want 0", k, rx_valid); end
            if (k == 0) begin valid = 1'b0; input_tx = W'($urandom); err = 1'($urandom); end
            if (k == 3) valid = 1'b1;
            if (k == FL - 1) valid = 1'b0;
        end
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL lb_ready_back got %b want 1", ready); end
        checks++; if (Tx !== 1'b1) begin failures++; $display("FAIL lb_tx_idle got %b want 1", Tx); end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL lb_rx_valid got %b want 1", rx_valid); end
        checks++; if (rx_data !== word) begin failures++; $display("FAIL lb_rx_data got %h want %h", rx_data, word); end
        checks++; if (rx_err !== inv) begin failures++; $display("FAIL lb_rx_err got %b want %b", rx_err, inv); end
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL lb_rx_valid_pulse got %b want 0", rx_valid); end
        checks++; if (rx_data !== word) begin failures++; $display("FAIL lb_rx_data_hold got %h want %h", rx_data, word); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0]  words [2];
        logic          invs [2];
        logic [FL-1:0] fb;
        words[0] = 16'h575D; invs[0] = 1'b1;
        words[1] = W'($urandom); invs[1] = 1'($urandom);
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_idle got %b want 1", ready); end
        valid = 1'b1; input_tx = words[0]; PF = 1'b0; err = invs[0];
        for (int f = 0; f < 2; f++) begin
            fb = frame_bits(words[f], 1'b0, invs[f]);
            for (int k = 0; k < FL; k++) begin
                @(negedge clk);
                checks++; if (Tx !== fb[k]) begin failures++; $display("FAIL b2b_tx f=%0d bit=%0d got %b want %b", f, k, Tx, fb[k]); end
                checks++; if (ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_busy f=%0d bit=%0d got %b want 0", f, k, ready); end
                if (f == 0 && k == 0) begin input_tx = words[1]; err = invs[1]; end
            end
            @(negedge clk);
            checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_gap f=%0d got %b want 1", f, ready); end
            checks++; if (Tx !== 1'b1) begin failures++; $display("FAIL b2b_tx_gap f=%0d got %b want 1", f, Tx); end
            checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL b2b_rx_valid f=%0d got %b want 1", f, rx_valid); end
            checks++; if (rx_data !== words[f]) begin failures++; $display("FAIL b2b_rx_data f=%0d got %h want %h", f, rx_data, words[f]); end
            checks++; if (rx_err !== invs[f]) begin failures++; $display("FAIL b2b_rx_err f=%0d got %b want %b", f, rx_err, invs[f]); end
            if (f == 1) valid = 1'b0;
        end
    endtask

    task automatic test_reset_midframe;
        logic [W-1:0]  word;
        logic [FL-1:0] fb;
        word = W'($urandom);
        @(negedge clk);
        valid = 1'b1; input_tx = word; PF = 1'($urandom); err = 1'b0;
        fb = frame_bits(word, PF, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (Tx !== fb[k]) begin failures++; $display("FAIL mid_tx bit=%0d got %b want %b", k, Tx, fb[k]); end
            if (k == 0) valid = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (Tx !== 1'b1) begin failures++; $display("FAIL mid_rst_tx got %b want 1", Tx); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got %b want 1", ready); end
        checks++; if (rx_data !== '0) begin failures++; $display("FAIL mid_rst_rx_data got %h want 0", rx_data); end
        reset = 1'b1;
        for (int c = 0; c < FL + 3; c++) begin
            @(negedge clk);
            checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL mid_no_rx_valid c=%0d got %b want 0", c, rx_valid); end
            checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mid_ready c=%0d got %b want 1", c, ready); end
        end
    endtask

    task automatic test_rx_direct;
        localparam int NF = 6;
        logic [W-1:0]  wd [NF];
        logic          pfs [NF];
        logic          perr [NF];
        logic [FL-1:0] fbs [NF];
        logic          exp_err [NF];
        for (int f = 0; f < NF; f++) begin
            logic stop0;
            wd[f]   = (f == 0) ? 16'h00FF : W'($urandom);
            pfs[f]  = (f == 0) ? 1'b0 : 1'($urandom);
            perr[f] = (f == 0) ? 1'b0 : 1'($urandom);
            stop0   = (f == 0) ? 1'b1 : 1'($urandom);
            fbs[f]  = frame_bits(wd[f], pfs[f], perr[f]);
            if (stop0) fbs[f][W+2] = 1'b0;
            exp_err[f] = perr[f] | (STOP_CHK & stop0);
        end
        @(negedge clk);
        loop_en = 1'b0; rx_drv = 1'b1;
        for (int f = 0; f <= NF; f++) begin
            for (int k = 0; k < FL; k++) begin
                @(negedge clk);
                if (k == 0 && f > 0) begin
                    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL rxd_valid f=%0d got %b want 1", f - 1, rx_valid); end
                    checks++; if (rx_data !== wd[f-1]) begin failures++; $display("FAIL rxd_data f=%0d got %h want %h", f - 1, rx_data, wd[f-1]); end
                    checks++; if (rx_err !== exp_err[f-1]) begin failures++; $display("FAIL rxd_err f=%0d got %b want %b", f - 1, rx_err, exp_err[f-1]); end
                end else begin
                    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rxd_valid_idle f=%0d bit=%0d got %b want 0", f, k, rx_valid); end
                end
                if (f == NF) begin
                    rx_drv = 1'b1;
                    break;
                end
                if (k == 0) PF = pfs[f];
                rx_drv = fbs[f][k];
            end
        end
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL rxd_valid_end got %b want 0", rx_valid); end
        loop_en = 1'b1;
    endtask

    initial begin
        test_reset;
        test_loopback(16'h5555, 1'b0, 1'b0);
        test_back_to_back;
        test_loopback(16'h5555, 1'b1, 1'b0);
        test_reset_midframe;
        for (int i = 0; i < 5; i++) test_loopback(W'($urandom), 1'($urandom), 1'($urandom));
        test_rx_direct;
        test_loopback(W'($urandom), 1'($urandom), 1'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
